// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and next-count function for the counter bank
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Widest channel the shared function supports; channels zero-extend into it.
  localparam int CNT_MAX_W = 32;

  typedef struct packed {
    logic [CNT_MAX_W-1:0] value;
    logic                 tc;
  } cnt_res_t;

  // Next count and terminal-count flag for one enabled update of a width-bit counter.
  // In saturate mode tc marks only the first arrival at the limit; a channel already
  // parked at the limit holds with tc low.
  function automatic cnt_res_t cnt_next(input logic [CNT_MAX_W-1:0] count,
                                        input logic [CNT_MAX_W-1:0] step,
                                        input logic                 dir,
                                        input logic                 sat,
                                        input int                   width);
    cnt_res_t             r;
    logic [CNT_MAX_W:0]   maxv;
    logic [CNT_MAX_W:0]   wide;
    logic [CNT_MAX_W-1:0] diff;
    maxv    = (33'd1 << width) - 33'd1;
    wide    = {1'b0, count} + {1'b0, step};
    diff    = count - step;
    r.value = '0;
    r.tc    = 1'b0;
    if (dir == DIR_UP) begin
      if (wide > maxv) begin
        if (sat == MODE_SAT) begin
          r.value = maxv[CNT_MAX_W-1:0];
          r.tc    = ({1'b0, count} != maxv);
        end else begin
          r.value = wide[CNT_MAX_W-1:0] & maxv[CNT_MAX_W-1:0];
          r.tc    = 1'b1;
        end
      end else begin
        r.value = wide[CNT_MAX_W-1:0];
        r.tc    = (sat == MODE_SAT) && (wide == maxv);
      end
    end else begin
      if (step > count) begin
        if (sat == MODE_SAT) begin
          r.value = '0;
          r.tc    = (count != '0);
        end else begin
          r.value = diff & maxv[CNT_MAX_W-1:0];
          r.tc    = 1'b1;
        end
      end else begin
        r.value = diff;
        r.tc    = (sat == MODE_SAT) && (diff == '0);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_ch.sv
// rtl/counter_ch.sv - one counter channel with load, up/down, wrap/saturate and tc pulse
module counter_ch
  import counter_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] START_VALUE = 'h0F,
  parameter int               STEP        = 1
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  cnt_res_t res;
  logic     unused_hi;

  // Candidate next value for an enabled update, computed on the zero-extended count.
  always_comb begin
    res = cnt_next(CNT_MAX_W'(count), CNT_MAX_W'(STEP), dir, sat, WIDTH);
  end

  assign unused_hi = ^res.value[CNT_MAX_W-1:WIDTH];

  // Count register: load beats enable beats hold; tc is a single-cycle pulse.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      count <= START_VALUE;
      tc    <= 1'b0;
    end else if (load) begin
      count <= load_val;
      tc    <= 1'b0;
    end else if (en) begin
      count <= res.value[WIDTH-1:0];
      tc    <= res.tc;
    end else begin
      tc    <= 1'b0;
    end
  end

endmodule

// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - multi-channel counter bank with registered LED tap
module counter_bank
  import counter_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               NUM_CH      = 4,
  parameter logic [WIDTH-1:0] START_VALUE = 'h0F,
  parameter int               STEP        = 1,
  parameter int               LED_W       = 2,
  parameter int               SEL_W       = $clog2(NUM_CH)
) (
  input  logic                    clock,
  input  logic                    rstn,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       dir,
  input  logic [NUM_CH-1:0]       sat,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
  input  logic [SEL_W-1:0]        led_sel,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       tc,
  output logic [LED_W-1:0]        led
);

  if (WIDTH < 2 || WIDTH > CNT_MAX_W - 1) begin : g_bad_width
    $error("counter_bank: WIDTH out of range");
  end
  if (NUM_CH < 2) begin : g_bad_num_ch
    $error("counter_bank: NUM_CH must be at least 2");
  end
  if (STEP < 1 || longint'(STEP) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_step
    $error("counter_bank: STEP out of range");
  end
  if (LED_W < 1 || LED_W > WIDTH) begin : g_bad_led_w
    $error("counter_bank: LED_W out of range");
  end

  logic [WIDTH-1:0] ch_count [NUM_CH];
  logic [LED_W-1:0] led_next;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    counter_ch #(
      .WIDTH       (WIDTH),
      .START_VALUE (START_VALUE),
      .STEP        (STEP)
    ) u_ch (
      .clock    (clock),
      .rstn     (rstn),
      .en       (en[g]),
      .dir      (dir[g]),
      .sat      (sat[g]),
      .load     (load[g]),
      .load_val (load_val[g*WIDTH +: WIDTH]),
      .count    (ch_count[g]),
      .tc       (tc[g])
    );
    assign count[g*WIDTH +: WIDTH] = ch_count[g];
  end

  // LED source mux; an out-of-range select falls back to channel 0.
  always_comb begin
    led_next = ch_count[0][WIDTH-1 -: LED_W];
    for (int i = 1; i < NUM_CH; i++) begin
      if (led_sel == SEL_W'(i)) begin
        led_next = ch_count[i][WIDTH-1 -: LED_W];
      end
    end
  end

  // LED register, one stage behind the count registers.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      led <= '0;
    end else begin
      led <= led_next;
    end
  end

endmodule

// File: tb/tb_counter_bank.sv
// tb/tb_counter_bank.sv - directed self-checking bench for counter_bank
module tb_counter_bank;
  import counter_pkg::*;

  logic        clock = 1'b0;
  logic        rstn;
  logic [3:0]  en, dir, sat, load;
  logic [31:0] load_val;
  logic [1:0]  led_sel;
  logic [31:0] count, count3;
  logic [3:0]  tc, tc3;
  logic [1:0]  led, led3;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  counter_bank #(
    .WIDTH(8), .NUM_CH(4), .START_VALUE(8'h0F), .STEP(1), .LED_W(2)
  ) dut (
    .clock(clock), .rstn(rstn), .en(en), .dir(dir), .sat(sat), .load(load),
    .load_val(load_val), .led_sel(led_sel), .count(count), .tc(tc), .led(led)
  );

  counter_bank #(
    .WIDTH(8), .NUM_CH(4), .START_VALUE(8'h0F), .STEP(3), .LED_W(2)
  ) dut3 (
    .clock(clock), .rstn(rstn), .en(en), .dir(dir), .sat(sat), .load(load),
    .load_val(load_val), .led_sel(led_sel), .count(count3), .tc(tc3), .led(led3)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 4'hF; dir = 4'hF; sat = 4'h0; load = 4'h0;
    load_val = 32'h0; led_sel = 2'd0;
    tick(); tick();
    checks++; if (count !== 32'h0F0F0F0F) begin failures++; $display("FAIL reset_count got=%h exp=%h", count, 32'h0F0F0F0F); end
    checks++; if (tc !== 4'h0) begin failures++; $display("FAIL reset_tc got=%b exp=0000", tc); end
    checks++; if (led !== 2'b00) begin failures++; $display("FAIL reset_led got=%b exp=00", led); end
    rstn = 1'b1;
    tick();
    checks++; if (count !== 32'h10101010) begin failures++; $display("FAIL release_first_inc got=%h exp=%h", count, 32'h10101010); end
    tick(); tick();
    #3 rstn = 1'b0;
    #1;
    checks++; if (count !== 32'h0F0F0F0F) begin failures++; $display("FAIL async_reset_count got=%h exp=%h", count, 32'h0F0F0F0F); end
    checks++; if (tc !== 4'h0 || led !== 2'b00) begin failures++; $display("FAIL async_reset_tc_led got tc=%b led=%b exp 0000/00", tc, led); end
    rstn = 1'b1;
    tick();
    checks++; if (count !== 32'h10101010) begin failures++; $display("FAIL rerelease_inc got=%h exp=%h", count, 32'h10101010); end
    en = 4'h0;
  endtask

  task automatic test_wrap_up();
    load = 4'b0001; load_val = 32'h000000FE; en = 4'h0;
    tick();
    checks++; if (count[7:0] !== 8'hFE) begin failures++; $display("FAIL wrap_load got=%h exp=fe", count[7:0]); end
    load = 4'h0; en = 4'b0001; dir = 4'b0001; sat = 4'h0;
    tick();
    checks++; if (count[7:0] !== 8'hFF || tc !== 4'b0000) begin failures++; $display("FAIL wrap_ff got=%h tc=%b exp ff/0000", count[7:0], tc); end
    tick();
    checks++; if (count[7:0] !== 8'h00 || tc !== 4'b0001) begin failures++; $display("FAIL wrap_00 got=%h tc=%b exp 00/0001", count[7:0], tc); end
    tick();
    checks++; if (count[7:0] !== 8'h01 || tc !== 4'b0000) begin failures++; $display("FAIL wrap_01 got=%h tc=%b exp 01/0000", count[7:0], tc); end
    checks++; if (count[31:8] !== 24'h101010) begin failures++; $display("FAIL wrap_others_hold got=%h exp=101010", count[31:8]); end
    en = 4'h0;
  endtask

  task automatic test_sat_down();
    load = 4'b0010; load_val = 32'h00000400; en = 4'h0;
    tick();
    checks++; if (count3[15:8] !== 8'h04) begin failures++; $display("FAIL sat_load got=%h exp=04", count3[15:8]); end
    load = 4'h0; en = 4'b0010; dir = 4'b0000; sat = 4'b0010;
    tick();
    checks++; if (count3[15:8] !== 8'h01 || tc3 !== 4'b0000) begin failures++; $display("FAIL sat_01 got=%h tc=%b exp 01/0000", count3[15:8], tc3); end
    tick();
    checks++; if (count3[15:8] !== 8'h00 || tc3 !== 4'b0010) begin failures++; $display("FAIL sat_clamp got=%h tc=%b exp 00/0010", count3[15:8], tc3); end
    tick();
    checks++; if (count3[15:8] !== 8'h00 || tc3 !== 4'b0000) begin failures++; $display("FAIL sat_hold got=%h tc=%b exp 00/0000", count3[15:8], tc3); end
    en = 4'h0; sat = 4'h0;
  endtask

  task automatic test_priority();
    load = 4'hF; load_val = 32'h40FF2010; en = 4'h0;
    tick();
    load = 4'b0100; load_val = 32'h00550000; en = 4'hF; dir = 4'hF; sat = 4'h0;
    tick();
    checks++; if (count !== 32'h41552111) begin failures++; $display("FAIL prio_count got=%h exp=%h", count, 32'h41552111); end
    checks++; if (tc !== 4'h0) begin failures++; $display("FAIL prio_tc got=%b exp=0000", tc); end
    load = 4'h0;
    tick();
    checks++; if (count !== 32'h42562212 || tc !== 4'h0) begin failures++; $display("FAIL prio_next got=%h tc=%b exp 42562212/0000", count, tc); end
    en = 4'h0;
  endtask

  task automatic test_led();
    en = 4'h0; load = 4'b1001; load_val = 32'hC000000F; led_sel = 2'd3;
    tick();
    checks++; if (count[31:24] !== 8'hC0 || led !== 2'b01) begin failures++; $display("FAIL led_lag got ch3=%h led=%b exp c0/01", count[31:24], led); end
    load = 4'h0;
    tick();
    checks++; if (led !== 2'b11) begin failures++; $display("FAIL led_ch3 got=%b exp=11", led); end
    led_sel = 2'd0;
    tick();
    checks++; if (led !== 2'b00) begin failures++; $display("FAIL led_ch0 got=%b exp=00", led); end
  endtask

  task automatic test_independence();
    cnt_res_t r0, r1;
    logic [7:0] m0, m1;
    int w0, w1;
    load = 4'b0011; load_val = 32'h00000AF0; en = 4'h0;
    tick();
    load = 4'h0; en = 4'b0011; dir = 4'b0001; sat = 4'h0;
    m0 = 8'hF0; m1 = 8'h0A; w0 = 0; w1 = 0;
    for (int i = 0; i < 300; i++) begin
      r0 = cnt_next(32'(m0), 32'd1, DIR_UP, MODE_WRAP, 8);
      r1 = cnt_next(32'(m1), 32'd1, DIR_DOWN, MODE_WRAP, 8);
      m0 = r0.value[7:0];
      m1 = r1.value[7:0];
      tick();
      checks++;
      if (count[15:0] !== {m1, m0} || tc[1:0] !== {r1.tc, r0.tc}) begin
        failures++;
        $display("FAIL indep_cycle%0d got=%h tc=%b exp=%h tc=%b", i, count[15:0], tc[1:0], {m1, m0}, {r1.tc, r0.tc});
      end
      if (tc[0]) w0++;
      if (tc[1]) w1++;
    end
    checks++; if (count[15:0] !== 16'hDE1C) begin failures++; $display("FAIL indep_final got=%h exp=de1c", count[15:0]); end
    checks++; if (w0 != 2 || w1 != 2) begin failures++; $display("FAIL indep_tc_pulses got=%0d/%0d exp=2/2", w0, w1); end
    checks++; if (count[31:16] !== 16'hC056) begin failures++; $display("FAIL indep_idle_hold got=%h exp=c056", count[31:16]); end
    en = 4'h0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_priority();
    test_led();
    test_independence();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
